// File: rtl/beep_arb_pkg.sv
// Shared types and helpers for the beep arbiter: FSM encoding, tick divisor
// and the round-robin pick function.
package beep_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int unsigned C_FCK_DEFAULT = 48_000_000;
  localparam int unsigned C_MS_PER_S    = 1000;
  localparam int unsigned C_TICK_DIV_DEFAULT = C_FCK_DEFAULT / C_MS_PER_S;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } grant_t;

  // Number of clock cycles in one 1 ms tick.
  function automatic int unsigned tick_div(input int unsigned fck);
    return fck / C_MS_PER_S;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Search starts one past the last granted requester and wraps 3 -> 0.
  function automatic grant_t rr_pick(input logic [3:0] req, input logic [1:0] last);
    grant_t     g;
    logic [1:0] cand;
    g = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!g.valid && req[cand]) begin
        g.valid = 1'b1;
        g.idx   = cand;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/beep_arb_ms_tick.sv
// 1 ms prescaler: TICK_o is high on the last cycle of every C_DIV-cycle
// period; RESTART_i realigns the period so durations start cycle-exact.
module ms_tick #(
  parameter int unsigned C_DIV = 48_000
) (
  input  logic CK_i,
  input  logic XARST_i,
  input  logic RESTART_i,
  output logic TICK_o
);

  localparam int unsigned    C_W    = (C_DIV > 1) ? $clog2(C_DIV) : 1;
  localparam logic [C_W-1:0] C_LAST = C_W'(C_DIV - 1);

  logic [C_W-1:0] cnt;

  always_ff @(posedge CK_i) begin
    if (!XARST_i) begin
      cnt <= '0;
    end else if (RESTART_i || cnt == C_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + C_W'(1);
    end
  end

  assign TICK_o = (cnt == C_LAST);

endmodule

// File: rtl/beep_arb.sv
// Beep arbiter: grants one of four tone requesters round-robin, plays its key
// for LEN ms, then holds a fixed silent gap before the next grant.
module beep_arb
  import beep_arb_pkg::*;
#(
  parameter int unsigned C_FCK    = C_FCK_DEFAULT,
  parameter int unsigned C_GAP_MS = 10
) (
  input  logic       CK_i,
  input  logic       XARST_i,
  input  logic [3:0] REQ_i,
  input  logic [7:0] KEY0_i,
  input  logic [7:0] KEY1_i,
  input  logic [7:0] KEY2_i,
  input  logic [7:0] KEY3_i,
  input  logic [7:0] LEN0_i,
  input  logic [7:0] LEN1_i,
  input  logic [7:0] LEN2_i,
  input  logic [7:0] LEN3_i,
  input  logic       ABORT_i,
  output logic [3:0] ACK_o,
  output logic [3:0] DONE_o,
  output logic [7:0] KEY_o,
  output logic       BUSY_o
);

  localparam int unsigned C_DIV      = tick_div(C_FCK);
  localparam logic [7:0]  C_GAP_LAST = 8'(C_GAP_MS - 1);

  state_t     state;
  logic [1:0] rr_ptr;
  logic [7:0] key_lat;
  logic [7:0] len_lat;
  logic [7:0] ticks;
  logic [7:0] sel_key;
  logic [7:0] sel_len;
  logic       tick;
  logic       restart;
  logic       tone_end;
  logic       gap_end;
  grant_t     pick;

  ms_tick #(
    .C_DIV(C_DIV)
  ) u_ms_tick (
    .CK_i      (CK_i),
    .XARST_i   (XARST_i),
    .RESTART_i (restart),
    .TICK_o    (tick)
  );

  // Counters are held at zero in IDLE and cleared again on the TONE->GAP
  // edge, so both phases start from a fresh prescaler period.
  always_comb begin
    pick    = rr_pick(REQ_i, rr_ptr);
    sel_key = KEY0_i;
    sel_len = LEN0_i;
    case (pick.idx)
      2'd1: begin
        sel_key = KEY1_i;
        sel_len = LEN1_i;
      end
      2'd2: begin
        sel_key = KEY2_i;
        sel_len = LEN2_i;
      end
      2'd3: begin
        sel_key = KEY3_i;
        sel_len = LEN3_i;
      end
      default: begin
        sel_key = KEY0_i;
        sel_len = LEN0_i;
      end
    endcase
    tone_end = (state == ST_TONE) && (ABORT_i || ticks == len_lat);
    gap_end  = (state == ST_GAP) && (ABORT_i || (tick && ticks == C_GAP_LAST));
    restart  = (state == ST_IDLE) || tone_end;
  end

  always_ff @(posedge CK_i) begin
    if (!XARST_i) begin
      ticks <= '0;
    end else if (restart) begin
      ticks <= '0;
    end else if (tick) begin
      ticks <= ticks + 8'd1;
    end
  end

  // The key appears one cycle after ACK and stays for exactly LEN ticks;
  // rr_ptr doubles as the index of the requester currently being served.
  always_ff @(posedge CK_i) begin
    if (!XARST_i) begin
      state   <= ST_IDLE;
      rr_ptr  <= 2'd3;
      key_lat <= '0;
      len_lat <= '0;
      ACK_o   <= '0;
      DONE_o  <= '0;
      KEY_o   <= '0;
      BUSY_o  <= 1'b0;
    end else begin
      ACK_o  <= '0;
      DONE_o <= '0;
      case (state)
        ST_IDLE: begin
          KEY_o <= '0;
          if (pick.valid) begin
            ACK_o   <= onehot4(pick.idx);
            rr_ptr  <= pick.idx;
            key_lat <= sel_key;
            len_lat <= sel_len;
            BUSY_o  <= 1'b1;
            state   <= ST_TONE;
          end
        end
        ST_TONE: begin
          if (tone_end) begin
            KEY_o  <= '0;
            DONE_o <= onehot4(rr_ptr);
            state  <= ST_GAP;
          end else begin
            KEY_o <= key_lat;
          end
        end
        ST_GAP: begin
          KEY_o <= '0;
          if (gap_end) begin
            BUSY_o <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          KEY_o  <= '0;
          BUSY_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beep_arb.sv
// Self-checking bench for beep_arb at 10 kHz (10-cycle tick) with a 2 ms gap:
// directed scenarios plus randomized traffic against a cycle-countdown model.
module tb_beep_arb;

  localparam int unsigned C_FCK     = 10_000;
  localparam int unsigned C_GAP_MS  = 2;
  localparam int          C_TICK    = 10;
  localparam int          C_GAP_CYC = 20;

  logic       clk = 1'b0;
  logic       xarst;
  logic [3:0] req;
  logic [7:0] key_in [4];
  logic [7:0] len_in [4];
  logic       abort;
  logic [3:0] ack;
  logic [3:0] done;
  logic [7:0] key;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode 0 idle, 1 tone, 2 gap; m_left counts remaining cycles.
  int         m_mode = 0;
  int         m_left = 0;
  int         m_last = 3;
  int         m_cur  = 0;
  logic [7:0] m_key  = '0;
  logic [3:0] e_ack  = '0;
  logic [3:0] e_done = '0;
  logic [7:0] e_key  = '0;
  logic       e_busy = 1'b0;

  beep_arb #(
    .C_FCK    (C_FCK),
    .C_GAP_MS (C_GAP_MS)
  ) dut (
    .CK_i    (clk),
    .XARST_i (xarst),
    .REQ_i   (req),
    .KEY0_i  (key_in[0]),
    .KEY1_i  (key_in[1]),
    .KEY2_i  (key_in[2]),
    .KEY3_i  (key_in[3]),
    .LEN0_i  (len_in[0]),
    .LEN1_i  (len_in[1]),
    .LEN2_i  (len_in[2]),
    .LEN3_i  (len_in[3]),
    .ABORT_i (abort),
    .ACK_o   (ack),
    .DONE_o  (done),
    .KEY_o   (key),
    .BUSY_o  (busy)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit found;
    int c;
    if (!xarst) begin
      m_mode = 0;
      m_last = 3;
      m_left = 0;
      e_ack  = '0;
      e_done = '0;
      e_key  = '0;
      e_busy = 1'b0;
      return;
    end
    e_ack  = '0;
    e_done = '0;
    case (m_mode)
      0: begin
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
          c = (m_last + i) % 4;
          if (!found && req[c]) begin
            found = 1'b1;
            m_cur = c;
          end
        end
        if (found) begin
          m_last = m_cur;
          e_ack  = 4'(1 << m_cur);
          m_key  = key_in[m_cur];
          m_left = int'(len_in[m_cur]) * C_TICK;
          m_mode = 1;
          e_busy = 1'b1;
        end
      end
      1: begin
        if (abort || m_left == 0) begin
          e_key  = '0;
          e_done = 4'(1 << m_cur);
          m_mode = 2;
          m_left = C_GAP_CYC;
        end else begin
          e_key  = m_key;
          m_left = m_left - 1;
        end
      end
      default: begin
        e_key  = '0;
        m_left = m_left - 1;
        if (abort || m_left == 0) begin
          m_mode = 0;
          e_busy = 1'b0;
        end
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      if (!busy) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    xarst = 1'b0;
    tick();
    tick();
    n_checks++; if (ack !== 4'b0000) $display("[TB] FAIL reset_ack: got %b want 0000", ack); else n_pass++;
    n_checks++; if (done !== 4'b0000) $display("[TB] FAIL reset_done: got %b want 0000", done); else n_pass++;
    n_checks++; if (key !== 8'h00) $display("[TB] FAIL reset_key: got %h want 00", key); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else n_pass++;
    xarst = 1'b1;
    tick();
  endtask

  task automatic test_single_tone();
    int tone_n;
    int gap_n;
    bit quiet;
    key_in[0] = 8'h40;
    len_in[0] = 8'd3;
    req = 4'b0001;
    tick();
    n_checks++; if (ack !== 4'b0001) $display("[TB] FAIL single_ack: got %b want 0001", ack); else n_pass++;
    req = 4'b0000;
    tick();
    tone_n = 0;
    while (key === 8'h40 && tone_n < 300) begin
      tone_n++;
      tick();
    end
    n_checks++; if (tone_n != 3 * C_TICK) $display("[TB] FAIL single_tone_len: got %0d want %0d", tone_n, 3 * C_TICK); else n_pass++;
    n_checks++; if (done !== 4'b0001) $display("[TB] FAIL single_done: got %b want 0001", done); else n_pass++;
    gap_n = 0;
    quiet = 1'b1;
    while (busy && gap_n < 300) begin
      if (key !== 8'h00) quiet = 1'b0;
      gap_n++;
      tick();
    end
    n_checks++; if (gap_n != C_GAP_CYC) $display("[TB] FAIL single_gap_len: got %0d want %0d", gap_n, C_GAP_CYC); else n_pass++;
    n_checks++; if (!quiet) $display("[TB] FAIL single_gap_quiet: got key active want 00"); else n_pass++;
  endtask

  task automatic test_zero_len();
    int gap_n;
    bit quiet;
    key_in[2] = 8'h55;
    len_in[2] = 8'd0;
    req = 4'b0100;
    tick();
    n_checks++; if (ack !== 4'b0100) $display("[TB] FAIL zero_ack: got %b want 0100", ack); else n_pass++;
    req = 4'b0000;
    tick();
    n_checks++; if (done !== 4'b0100) $display("[TB] FAIL zero_done: got %b want 0100", done); else n_pass++;
    gap_n = 0;
    quiet = 1'b1;
    while (busy && gap_n < 300) begin
      if (key !== 8'h00) quiet = 1'b0;
      gap_n++;
      tick();
    end
    n_checks++; if (gap_n != C_GAP_CYC) $display("[TB] FAIL zero_gap_len: got %0d want %0d", gap_n, C_GAP_CYC); else n_pass++;
    n_checks++; if (!quiet) $display("[TB] FAIL zero_key_quiet: got key active want 00"); else n_pass++;
  endtask

  task automatic test_abort();
    int gap_n;
    bit ok;
    key_in[0] = 8'h21;
    len_in[0] = 8'd3;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (key !== 8'h21) $display("[TB] FAIL abort_pre_key: got %h want 21", key); else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (key !== 8'h00) $display("[TB] FAIL abort_key: got %h want 00", key); else n_pass++;
    n_checks++; if (done !== 4'b0001) $display("[TB] FAIL abort_done: got %b want 0001", done); else n_pass++;
    gap_n = 0;
    while (busy && gap_n < 300) begin
      gap_n++;
      tick();
    end
    n_checks++; if (gap_n != C_GAP_CYC) $display("[TB] FAIL abort_gap_len: got %0d want %0d", gap_n, C_GAP_CYC); else n_pass++;
    len_in[0] = 8'd0;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_in_gap_busy: got %b want 0", busy); else n_pass++;
    req = 4'b0000;
    tick();
    n_checks++; if (ack !== 4'b0000 || busy !== 1'b0) $display("[TB] FAIL abort_idle_ignored: got ack %b busy %b want 0000 0", ack, busy); else n_pass++;
    key_in[1] = 8'h33;
    len_in[1] = 8'd1;
    req = 4'b0010;
    tick();
    abort = 1'b0;
    req = 4'b0000;
    n_checks++; if (ack !== 4'b0010) $display("[TB] FAIL abort_idle_grant: got %b want 0010", ack); else n_pass++;
    wait_idle(ok);
    n_checks++; if (!ok) $display("[TB] FAIL abort_idle_timeout: got busy want idle"); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    logic [3:0] got     [5];
    int n;
    bit ok;
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    xarst = 1'b0;
    tick();
    xarst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      key_in[i] = 8'(8'h10 + i);
      len_in[i] = 8'd1;
    end
    req = 4'b1111;
    n = 0;
    for (int c = 0; c < 400 && n < 5; c++) begin
      tick();
      if (ack !== 4'b0000) begin
        got[n] = ack;
        n++;
      end
    end
    req = 4'b0000;
    n_checks++; if (n != 5) $display("[TB] FAIL rr_grant_count: got %0d want 5", n); else n_pass++;
    for (int i = 0; i < n; i++) begin
      n_checks++; if (got[i] !== exp_seq[i]) $display("[TB] FAIL rr_order_%0d: got %b want %b", i, got[i], exp_seq[i]); else n_pass++;
    end
    wait_idle(ok);
    n_checks++; if (!ok) $display("[TB] FAIL rr_idle_timeout: got busy want idle"); else n_pass++;
  endtask

  task automatic test_reset_mid_tone();
    bit ok;
    key_in[1] = 8'h11;
    len_in[1] = 8'd2;
    key_in[3] = 8'h77;
    len_in[3] = 8'd2;
    req = 4'b1010;
    tick();
    n_checks++; if (ack !== 4'b0010) $display("[TB] FAIL rst_mid_first_ack: got %b want 0010", ack); else n_pass++;
    for (int i = 0; i < 5; i++) tick();
    xarst = 1'b0;
    tick();
    xarst = 1'b1;
    n_checks++; if (key !== 8'h00) $display("[TB] FAIL rst_mid_key: got %h want 00", key); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 4'b0000) $display("[TB] FAIL rst_mid_done: got %b want 0000", done); else n_pass++;
    tick();
    n_checks++; if (ack !== 4'b0010) $display("[TB] FAIL rst_mid_regrant: got %b want 0010", ack); else n_pass++;
    req = 4'b0000;
    wait_idle(ok);
    n_checks++; if (!ok) $display("[TB] FAIL rst_mid_idle_timeout: got busy want idle"); else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] pend;
    pend = '0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i]   = 1'b1;
          key_in[i] = 8'($urandom);
          len_in[i] = 8'($urandom_range(0, 4));
        end else if (pend[i] && $urandom_range(0, 199) == 0) begin
          pend[i] = 1'b0;
        end
      end
      req   = pend;
      abort = ($urandom_range(0, 63) == 0);
      xarst = ($urandom_range(0, 799) != 0);
      tick();
      n_checks++;
      if ({ack, done, key, busy} !== {e_ack, e_done, e_key, e_busy})
        $display("[TB] FAIL rand_cycle_%0d: got ack %b done %b key %h busy %b want ack %b done %b key %h busy %b",
                 cyc, ack, done, key, busy, e_ack, e_done, e_key, e_busy);
      else n_pass++;
      n_checks++;
      if (!($onehot0(ack) && $onehot0(done) && !((|ack) && (|done))))
        $display("[TB] FAIL rand_onehot_%0d: got ack %b done %b want exclusive one-hot", cyc, ack, done);
      else n_pass++;
      pend = pend & ~ack;
    end
    req   = '0;
    abort = 1'b0;
    xarst = 1'b1;
  endtask

  initial begin
    xarst = 1'b0;
    req   = '0;
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_in[i] = '0;
      len_in[i] = '0;
    end
    test_reset();
    test_single_tone();
    test_zero_len();
    test_abort();
    test_round_robin();
    test_reset_mid_tone();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/beep_arb.md
BEEP_ARB -- requirements
Module: beep_arb

Interface
REQ-001 Parameter C_FCK, default 48_000_000, SHALL be the clock frequency in Hz; the tick period SHALL be C_FCK/1000 cycles (1 ms).
REQ-002 Parameter C_GAP_MS, default 10, SHALL be the silent gap in ticks inserted after every tone; range 1..255.
REQ-003 CK_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 XARST_i  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 REQ_i  in  4  SHALL be per-requester level requests, held until ACK_o for that requester.
REQ-006 KEY0_i..KEY3_i  in  8 each  SHALL be the tone key per requester, sampled at grant.
REQ-007 LEN0_i..LEN3_i  in  8 each  SHALL be the tone length in ticks per requester, sampled at grant.
REQ-008 ABORT_i  in  1  SHALL be a synchronous request to cut the current tone/gap.
REQ-009 ACK_o  out  4  SHALL be a one-cycle one-hot grant pulse.
REQ-010 DONE_o  out  4  SHALL be a one-cycle one-hot pulse when the granted tone ends (normal or aborted).
REQ-011 KEY_o  out  8  SHALL be the key driven to the tone generator; 0 means silent.
REQ-012 BUSY_o  out  1  SHALL be high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, TONE, GAP.
REQ-014 IDLE: when any REQ_i bit is high, the block SHALL grant one requester by round-robin, starting the search at (last granted index + 1) mod 4.
REQ-015 On grant the block SHALL pulse ACK_o[g], latch KEYg_i and LENg_i, and enter TONE on the next cycle; the grant decision SHALL take one cycle (ACK_o asserted the cycle after REQ_i is first seen high in IDLE).
REQ-016 TONE: KEY_o SHALL equal the latched key for exactly LEN*C_FCK/1000 cycles, then the block SHALL pulse DONE_o[g] and enter GAP.
REQ-017 LEN = 0 SHALL skip TONE: DONE_o[g] pulses the cycle after ACK_o and the FSM enters GAP; KEY_o stays 0.
REQ-018 GAP: KEY_o SHALL be 0 for exactly C_GAP_MS*C_FCK/1000 cycles, then IDLE.
REQ-019 The tick prescaler and tick counter SHALL restart at entry to TONE and GAP so durations are cycle-exact.
REQ-020 ABORT_i high in TONE SHALL, on the next cycle, force KEY_o to 0, pulse DONE_o[g], and enter GAP; ABORT_i in GAP SHALL enter IDLE immediately; in IDLE it SHALL be ignored.
REQ-021 REQ_i changes during TONE/GAP SHALL not affect the current tone; a requester dropping REQ_i before grant SHALL be simply skipped.
REQ-022 ACK_o and DONE_o SHALL never be high for more than one requester, and never both high in the same cycle.
REQ-023 The round-robin pointer SHALL wrap from 3 to 0.

Reset
REQ-024 While XARST_i = 0 at a clock edge, the block SHALL enter IDLE; ACK_o = 0, DONE_o = 0, KEY_o = 0, BUSY_o = 0; prescaler, tick counter and latched key/length SHALL be 0; the round-robin pointer SHALL be 3 (requester 0 highest priority first).
REQ-025 Reset mid-tone SHALL silence KEY_o the cycle after the reset edge with no DONE_o pulse.

Structure
REQ-026 State encoding and the tick-divisor constant (C_FCK/1000) SHALL live in a shared package.
REQ-027 The 1 ms prescaler with synchronous restart SHALL be one sub-module, ms_tick.

Verification (C_FCK = 10_000, tick = 10 cycles, C_GAP_MS = 2)
REQ-028 REQ_i=0001, KEY0=0x40, LEN0=3 -> ACK_o=0001 one cycle later; KEY_o=0x40 for 30 cycles; DONE_o=0001; KEY_o=0 for 20 cycles; BUSY_o low after.
REQ-029 REQ_i=1111 held for four tones -> grants in order 0,1,2,3; next grant (requests held) is 0.
REQ-030 REQ_i=0100 with LEN2=0 -> ACK_o=0100, DONE_o=0100 next cycle, KEY_o stays 0, 20-cycle gap.
REQ-031 ABORT_i pulsed 5 cycles into a 30-cycle tone -> KEY_o=0 and DONE_o pulse the next cycle, then full 20-cycle gap.
REQ-032 XARST_i=0 for one cycle mid-tone -> KEY_o=0, BUSY_o=0, no DONE_o; with REQ_i=1010 held, first grant after reset is 1.
